// File: rtl/arq_pkg.sv
// Shared encodings for the multi-LT ARQ flow controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arq_pkg;

  localparam int NUM_LT_DEF   = 8;
  localparam int MAX_RETX_DEF = 7;

  // Per-LT transmit state
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_FLUSH    = 2'd2
  } tx_state_e;

  // tx_sel encodings
  localparam logic [1:0] SEL_NEW  = 2'd0;  // new payload
  localparam logic [1:0] SEL_RETX = 2'd1;  // retransmit
  localparam logic [1:0] SEL_ZLC  = 2'd2;  // zero-length continue
  localparam logic [1:0] SEL_NULL = 2'd3;  // NULL packet

endpackage

// File: rtl/arq_lt_txfsm.sv
// Per-LT transmit FSM with retransmission counter; ACK, then flush, then TX are applied in one cycle.
// Latency: state updates on the next clock; sel/new/drop are combinational for the current slot.
// Backpressure: none; the parent gates tx_i when the remote side has signalled STOP.
module arq_lt_txfsm
  import arq_pkg::*;
#(
  parameter int MAX_RETX = MAX_RETX_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       conn_new_i,
  input  logic       ack_i,
  input  logic       flush_i,
  input  logic       tx_i,
  output logic [1:0] sel_o,
  output logic       new_o,
  output logic       drop_o
);

  localparam logic [3:0] MAX_C = 4'(MAX_RETX);

  tx_state_e   state_q, state_d, base_state;
  logic [3:0]  cnt_q, cnt_d;

  // An ACK wins over a flush; the TX slot then sees the post-ACK/flush state
  assign base_state = ack_i ? ST_IDLE :
                      (flush_i && state_q == ST_WAIT_ACK) ? ST_FLUSH : state_q;

  // State and retransmission counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: new connection resets, otherwise advance on a data TX slot
  always_comb begin
    state_d = base_state;
    cnt_d   = cnt_q;
    if (conn_new_i) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (tx_i) begin
      case (base_state)
        ST_IDLE: begin
          state_d = ST_WAIT_ACK;
          cnt_d   = 4'd0;
        end
        ST_WAIT_ACK: begin
          if (cnt_q == MAX_C) state_d = ST_FLUSH;
          else                cnt_d   = cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Slot outputs: payload selection, SEQN toggle request and auto-flush indication
  always_comb begin
    sel_o  = SEL_ZLC;
    new_o  = 1'b0;
    drop_o = 1'b0;
    case (base_state)
      ST_IDLE: begin
        sel_o = SEL_NEW;
        new_o = tx_i;
      end
      ST_WAIT_ACK: begin
        if (cnt_q == MAX_C) drop_o = tx_i;
        else                sel_o  = SEL_RETX;
      end
      default: sel_o = SEL_ZLC;
    endcase
  end

endmodule

// File: rtl/arq_flow_ctrl_mlt.sv
// Baseband ARQN/SEQN/FLOW controller tracking NUM_LT logical transports.
// Latency: TX header bits and RX verdict strobes are registered, one cycle after the triggering pulse.
// Backpressure: remote STOP turns data slots into NULL; local rx_buf_ready=0 rejects payloads and drives FLOW=0.
module arq_flow_ctrl_mlt
  import arq_pkg::*;
#(
  parameter int NUM_LT   = NUM_LT_DEF,
  parameter int LTW      = 3,
  parameter int MAX_RETX = MAX_RETX_DEF
) (
  input  logic              clk_6M,
  input  logic              rst,
  input  logic              conn_new_p,
  input  logic              tx_start_p,
  input  logic [LTW-1:0]    tx_lt,
  input  logic              tx_is_data,
  input  logic              flush_req_p,
  input  logic [LTW-1:0]    flush_lt,
  input  logic              rx_done_p,
  input  logic [LTW-1:0]    rx_lt,
  input  logic              rx_hec_ok,
  input  logic              rx_crc_ok,
  input  logic              rx_mic_ok,
  input  logic              rx_is_data,
  input  logic              rx_seqn,
  input  logic              rx_arqn,
  input  logic              rx_flow,
  input  logic              rx_buf_ready,
  output logic              tx_seqn,
  output logic              tx_arqn,
  output logic              tx_flow,
  output logic [1:0]        tx_sel,
  output logic              rx_accept_p,
  output logic              rx_ignore_p,
  output logic              rx_reject_p,
  output logic              retx_drop_p,
  output logic [NUM_LT-1:0] lt_arqn_vec,
  output logic [NUM_LT-1:0] lt_stop_vec
);

  logic [NUM_LT-1:0]      tx_hit, rx_hit, fl_hit, ack_hit, fsm_tx, fsm_new, fsm_drop;
  logic [NUM_LT-1:0][1:0] fsm_sel;
  logic [NUM_LT-1:0]      seqn_q, seqn_d, seqn_old_q, seqn_old_d;
  logic [NUM_LT-1:0]      arqn_q, arqn_d, stop_q, stop_d;
  logic                   tx_seqn_q, tx_seqn_d, tx_arqn_q, tx_arqn_d, tx_flow_q, tx_flow_d;
  logic [1:0]             tx_sel_q, tx_sel_d;
  logic                   acc_q, acc_d, ign_q, ign_d, rej_q, rej_d, drop_q, drop_d;

  // Per-LT decode; out-of-range indices match no LT and so have no effect
  for (genvar i = 0; i < NUM_LT; i++) begin : g_lt
    assign tx_hit[i]  = tx_start_p  & ~conn_new_p & (tx_lt    == LTW'(i));
    assign rx_hit[i]  = rx_done_p   & ~conn_new_p & (rx_lt    == LTW'(i));
    assign fl_hit[i]  = flush_req_p & ~conn_new_p & (flush_lt == LTW'(i));
    assign ack_hit[i] = rx_hit[i] & rx_hec_ok & rx_arqn;
    assign fsm_tx[i]  = tx_hit[i] & tx_is_data & ~stop_q[i];

    arq_lt_txfsm #(.MAX_RETX(MAX_RETX)) u_txfsm (
      .clk_i      (clk_6M),
      .rst_i      (rst),
      .conn_new_i (conn_new_p),
      .ack_i      (ack_hit[i]),
      .flush_i    (fl_hit[i]),
      .tx_i       (fsm_tx[i]),
      .sel_o      (fsm_sel[i]),
      .new_o      (fsm_new[i]),
      .drop_o     (fsm_drop[i])
    );
  end

  // TX header selection for the addressed LT; registers hold between slots
  always_comb begin
    tx_sel_d  = tx_sel_q;
    tx_seqn_d = tx_seqn_q;
    tx_arqn_d = tx_arqn_q;
    tx_flow_d = tx_flow_q;
    drop_d    = 1'b0;
    for (int i = 0; i < NUM_LT; i++) begin
      if (tx_hit[i]) begin
        tx_arqn_d = arqn_q[i];
        tx_flow_d = rx_buf_ready;
        tx_seqn_d = seqn_q[i] ^ fsm_new[i];
        if (!tx_is_data)     tx_sel_d = SEL_NEW;
        else if (stop_q[i])  tx_sel_d = SEL_NULL;
        else begin
          tx_sel_d = fsm_sel[i];
          drop_d   = fsm_drop[i];
        end
      end
    end
  end

  // RX verdict and per-LT SEQN/ARQN/STOP bookkeeping
  always_comb begin
    seqn_d     = seqn_q ^ fsm_new;
    seqn_old_d = seqn_old_q;
    arqn_d     = arqn_q;
    stop_d     = stop_q;
    acc_d      = 1'b0;
    ign_d      = 1'b0;
    rej_d      = 1'b0;
    if (conn_new_p) begin
      seqn_d     = '1;
      seqn_old_d = '0;
      arqn_d     = '0;
      stop_d     = '0;
    end else begin
      for (int i = 0; i < NUM_LT; i++) begin
        if (rx_hit[i]) begin
          if (!rx_hec_ok) begin
            rej_d = 1'b1;
          end else begin
            stop_d[i] = ~rx_flow;
            if (!rx_is_data) begin
              rej_d = 1'b1;
            end else if (rx_seqn == seqn_old_q[i]) begin
              ign_d     = 1'b1;
              arqn_d[i] = 1'b1;
            end else if (rx_crc_ok && rx_mic_ok && rx_buf_ready) begin
              acc_d         = 1'b1;
              seqn_old_d[i] = rx_seqn;
              arqn_d[i]     = 1'b1;
            end else begin
              rej_d     = 1'b1;
              arqn_d[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // State and output registers; reset matches a fresh connection
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      seqn_q     <= '1;
      seqn_old_q <= '0;
      arqn_q     <= '0;
      stop_q     <= '0;
      tx_seqn_q  <= 1'b1;
      tx_arqn_q  <= 1'b0;
      tx_flow_q  <= 1'b0;
      tx_sel_q   <= SEL_NULL;
      acc_q      <= 1'b0;
      ign_q      <= 1'b0;
      rej_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      seqn_q     <= seqn_d;
      seqn_old_q <= seqn_old_d;
      arqn_q     <= arqn_d;
      stop_q     <= stop_d;
      tx_seqn_q  <= tx_seqn_d;
      tx_arqn_q  <= tx_arqn_d;
      tx_flow_q  <= tx_flow_d;
      tx_sel_q   <= tx_sel_d;
      acc_q      <= acc_d;
      ign_q      <= ign_d;
      rej_q      <= rej_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_seqn     = tx_seqn_q;
  assign tx_arqn     = tx_arqn_q;
  assign tx_flow     = tx_flow_q;
  assign tx_sel      = tx_sel_q;
  assign rx_accept_p = acc_q;
  assign rx_ignore_p = ign_q;
  assign rx_reject_p = rej_q;
  assign retx_drop_p = drop_q;
  assign lt_arqn_vec = arqn_q;
  assign lt_stop_vec = stop_q;

endmodule

// File: tb/tb_arq_flow_ctrl_mlt.sv
// Bench for arq_flow_ctrl_mlt: directed scenarios plus randomized traffic against a reference model.
// Latency: every stimulus cycle is checked #1 after the following rising edge.
// Backpressure: n/a.
module tb_arq_flow_ctrl_mlt;

  localparam int NL = 6;   // fewer LTs than the index width covers, so indices 6 and 7 are out of range
  localparam int LW = 3;
  localparam int MR = 7;

  logic          clk_6M = 1'b0;
  logic          rst = 1'b1;
  logic          conn_new_p, tx_start_p, tx_is_data, flush_req_p, rx_done_p;
  logic [LW-1:0] tx_lt, flush_lt, rx_lt;
  logic          rx_hec_ok, rx_crc_ok, rx_mic_ok, rx_is_data, rx_seqn, rx_arqn, rx_flow, rx_buf_ready;
  logic          tx_seqn, tx_arqn, tx_flow;
  logic [1:0]    tx_sel;
  logic          rx_accept_p, rx_ignore_p, rx_reject_p, retx_drop_p;
  logic [NL-1:0] lt_arqn_vec, lt_stop_vec;

  int n_chk = 0;
  int n_fail = 0;

  arq_flow_ctrl_mlt #(.NUM_LT(NL), .LTW(LW), .MAX_RETX(MR)) dut (
    .clk_6M(clk_6M), .rst(rst), .conn_new_p(conn_new_p),
    .tx_start_p(tx_start_p), .tx_lt(tx_lt), .tx_is_data(tx_is_data),
    .flush_req_p(flush_req_p), .flush_lt(flush_lt),
    .rx_done_p(rx_done_p), .rx_lt(rx_lt), .rx_hec_ok(rx_hec_ok), .rx_crc_ok(rx_crc_ok),
    .rx_mic_ok(rx_mic_ok), .rx_is_data(rx_is_data), .rx_seqn(rx_seqn), .rx_arqn(rx_arqn),
    .rx_flow(rx_flow), .rx_buf_ready(rx_buf_ready),
    .tx_seqn(tx_seqn), .tx_arqn(tx_arqn), .tx_flow(tx_flow), .tx_sel(tx_sel),
    .rx_accept_p(rx_accept_p), .rx_ignore_p(rx_ignore_p), .rx_reject_p(rx_reject_p),
    .retx_drop_p(retx_drop_p), .lt_arqn_vec(lt_arqn_vec), .lt_stop_vec(lt_stop_vec)
  );

  always #5 clk_6M = ~clk_6M;

  // Reference model: abstract per-LT link state
  localparam int S_IDLE = 0, S_WAIT = 1, S_FLUSH = 2;
  int m_st[NL];
  int m_cnt[NL];
  bit m_seqn[NL], m_old[NL], m_arqn[NL], m_stop[NL];
  int e_sel, e_seqn, e_arqn, e_flow, e_drop, e_acc, e_ign, e_rej;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_conn();
    for (int i = 0; i < NL; i++) begin
      m_st[i] = S_IDLE; m_cnt[i] = 0;
      m_seqn[i] = 1'b1; m_old[i] = 1'b0; m_arqn[i] = 1'b0; m_stop[i] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_conn();
    e_sel = 3; e_seqn = 1; e_arqn = 0; e_flow = 0;
    e_drop = 0; e_acc = 0; e_ign = 0; e_rej = 0;
  endfunction

  // One slot: an ACK lands first, then a flush request, then the TX slot, then the RX verdict
  function automatic void model_step();
    e_drop = 0; e_acc = 0; e_ign = 0; e_rej = 0;
    if (conn_new_p) begin
      model_conn();
      return;
    end
    if (rx_done_p && rx_lt < NL && rx_hec_ok && rx_arqn) m_st[rx_lt] = S_IDLE;
    if (flush_req_p && flush_lt < NL && m_st[flush_lt] == S_WAIT) m_st[flush_lt] = S_FLUSH;
    if (tx_start_p && tx_lt < NL) begin
      int l = int'(tx_lt);
      e_arqn = m_arqn[l];
      e_flow = rx_buf_ready;
      if (!tx_is_data)  e_sel = 0;
      else if (m_stop[l]) e_sel = 3;
      else if (m_st[l] == S_IDLE) begin
        m_seqn[l] = ~m_seqn[l]; m_st[l] = S_WAIT; m_cnt[l] = 0; e_sel = 0;
      end else if (m_st[l] == S_WAIT) begin
        if (m_cnt[l] < MR) begin m_cnt[l]++; e_sel = 1; end
        else begin e_drop = 1; e_sel = 2; m_st[l] = S_FLUSH; end
      end else e_sel = 2;
      e_seqn = m_seqn[l];
    end
    if (rx_done_p && rx_lt < NL) begin
      int l = int'(rx_lt);
      if (!rx_hec_ok) e_rej = 1;
      else begin
        m_stop[l] = ~rx_flow;
        if (!rx_is_data) e_rej = 1;
        else if (rx_seqn == m_old[l]) begin e_ign = 1; m_arqn[l] = 1'b1; end
        else if (rx_crc_ok && rx_mic_ok && rx_buf_ready) begin
          e_acc = 1; m_old[l] = rx_seqn; m_arqn[l] = 1'b1;
        end else begin e_rej = 1; m_arqn[l] = 1'b0; end
      end
    end
  endfunction

  task automatic compare_all();
    int va = 0;
    int vs = 0;
    for (int i = 0; i < NL; i++) begin
      va |= int'(m_arqn[i]) << i;
      vs |= int'(m_stop[i]) << i;
    end
    chk("tx_sel", int'(tx_sel), e_sel);
    chk("tx_seqn", int'(tx_seqn), e_seqn);
    chk("tx_arqn", int'(tx_arqn), e_arqn);
    chk("tx_flow", int'(tx_flow), e_flow);
    chk("retx_drop", int'(retx_drop_p), e_drop);
    chk("rx_accept", int'(rx_accept_p), e_acc);
    chk("rx_ignore", int'(rx_ignore_p), e_ign);
    chk("rx_reject", int'(rx_reject_p), e_rej);
    chk("arqn_vec", int'(lt_arqn_vec), va);
    chk("stop_vec", int'(lt_stop_vec), vs);
  endtask

  task automatic idle_in();
    conn_new_p = 0; tx_start_p = 0; tx_lt = '0; tx_is_data = 0;
    flush_req_p = 0; flush_lt = '0; rx_done_p = 0; rx_lt = '0;
    rx_hec_ok = 1; rx_crc_ok = 1; rx_mic_ok = 1; rx_is_data = 1;
    rx_seqn = 0; rx_arqn = 0; rx_flow = 1; rx_buf_ready = 1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk_6M);
    #1;
    compare_all();
  endtask

  task automatic do_conn();
    idle_in(); conn_new_p = 1; step();
  endtask

  task automatic do_tx(input int lt, input bit data);
    idle_in(); tx_start_p = 1; tx_lt = LW'(lt); tx_is_data = data; step();
  endtask

  task automatic set_rx(input int lt, input bit data, input bit seqn, input bit arqn,
                        input bit flow, input bit crc);
    rx_done_p = 1; rx_lt = LW'(lt); rx_is_data = data; rx_seqn = seqn;
    rx_arqn = arqn; rx_flow = flow; rx_crc_ok = crc;
  endtask

  task automatic do_rx(input int lt, input bit data, input bit seqn, input bit arqn,
                       input bit flow, input bit crc);
    idle_in(); set_rx(lt, data, seqn, arqn, flow, crc); step();
  endtask

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(posedge clk_6M);
    #1;
    compare_all();
    chk("rst_sel", int'(tx_sel), 3);
    chk("rst_seqn", int'(tx_seqn), 1);
    rst = 1'b0;

    // New payload, ACK, next new payload with toggled SEQN
    do_conn();
    do_tx(2, 1);  chk("s31_sel_a", int'(tx_sel), 0); chk("s31_seqn_a", int'(tx_seqn), 0);
    do_rx(2, 0, 0, 1, 1, 1);
    do_tx(2, 1);  chk("s31_sel_b", int'(tx_sel), 0); chk("s31_seqn_b", int'(tx_seqn), 1);

    // Retransmission limit then auto-flush
    do_conn();
    do_tx(1, 1);  chk("s32_first", int'(tx_sel), 0);
    for (int k = 0; k < MR; k++) begin
      do_tx(1, 1); chk("s32_retx", int'(tx_sel), 1); chk("s32_nodrop", int'(retx_drop_p), 0);
    end
    do_tx(1, 1);  chk("s32_drop", int'(retx_drop_p), 1); chk("s32_zlc", int'(tx_sel), 2);
    do_tx(1, 1);  chk("s32_flush_hold", int'(tx_sel), 2);
    do_rx(1, 0, 0, 1, 1, 1);
    do_tx(1, 1);  chk("s32_after_ack", int'(tx_sel), 0);

    // Accept, duplicate ignore, CRC reject
    do_conn();
    do_rx(3, 1, 1, 0, 1, 1); chk("s33_acc", int'(rx_accept_p), 1); chk("s33_arqn1", int'(lt_arqn_vec[3]), 1);
    do_rx(3, 1, 1, 0, 1, 1); chk("s33_ign", int'(rx_ignore_p), 1);
    do_rx(3, 1, 0, 0, 1, 0); chk("s33_rej", int'(rx_reject_p), 1); chk("s33_arqn0", int'(lt_arqn_vec[3]), 0);

    // Local buffer full
    do_rx(5, 1, 1, 0, 1, 1); chk("s34_acc", int'(rx_accept_p), 1);
    idle_in(); set_rx(5, 1, 0, 0, 1, 1); rx_buf_ready = 0; step();
    chk("s34_rej", int'(rx_reject_p), 1); chk("s34_arqn0", int'(lt_arqn_vec[5]), 0);
    idle_in(); tx_start_p = 1; tx_lt = 3'd5; tx_is_data = 1; rx_buf_ready = 0; step();
    chk("s34_flow0", int'(tx_flow), 0);

    // Remote STOP then GO
    do_rx(4, 0, 0, 0, 0, 1); chk("s35_stop", int'(lt_stop_vec[4]), 1);
    do_tx(4, 1);  chk("s35_null", int'(tx_sel), 3);
    do_rx(4, 0, 0, 0, 1, 1); chk("s35_go", int'(lt_stop_vec[4]), 0);
    do_tx(4, 1);  chk("s35_resume", int'(tx_sel), 0);

    // Same-cycle ACK+TX, ACK+flush, and flush alone on LT 0
    do_conn();
    do_tx(0, 1);
    idle_in(); tx_start_p = 1; tx_lt = 3'd0; tx_is_data = 1; set_rx(0, 0, 0, 1, 1, 1); step();
    chk("s36_acktx_sel", int'(tx_sel), 0); chk("s36_acktx_seqn", int'(tx_seqn), 1);
    idle_in(); flush_req_p = 1; flush_lt = 3'd0; set_rx(0, 0, 0, 1, 1, 1); step();
    do_tx(0, 1);  chk("s36_ackflush", int'(tx_sel), 0);
    idle_in(); flush_req_p = 1; flush_lt = 3'd0; step();
    do_tx(0, 1);  chk("flush_only", int'(tx_sel), 2);

    // Out-of-range LT indices do nothing
    do_tx(7, 1);  chk("oor_tx_hold", int'(tx_sel), 2);
    do_rx(6, 1, 1, 1, 0, 1);
    chk("oor_rx_strobes", int'(rx_accept_p) + int'(rx_ignore_p) + int'(rx_reject_p), 0);

    // Reset asserted mid-slot leaves no residual strobe
    idle_in(); set_rx(2, 1, 1, 0, 1, 1);
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk_6M);
    #1;
    compare_all();
    rst = 1'b0;
    idle_in(); step();
    chk("rst_mid_acc", int'(rx_accept_p), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      conn_new_p   = ($urandom_range(0, 199) == 0);
      tx_start_p   = ($urandom_range(0, 1) == 1);
      tx_lt        = LW'($urandom_range(0, 7));
      tx_is_data   = ($urandom_range(0, 99) < 85);
      flush_req_p  = ($urandom_range(0, 9) == 0);
      flush_lt     = LW'($urandom_range(0, 7));
      rx_done_p    = ($urandom_range(0, 1) == 1);
      rx_lt        = LW'($urandom_range(0, 7));
      rx_hec_ok    = ($urandom_range(0, 9) != 0);
      rx_crc_ok    = ($urandom_range(0, 99) < 85);
      rx_mic_ok    = ($urandom_range(0, 9) != 0);
      rx_is_data   = ($urandom_range(0, 4) != 0);
      rx_seqn      = 1'($urandom_range(0, 1));
      rx_arqn      = ($urandom_range(0, 2) == 0);
      rx_flow      = ($urandom_range(0, 4) != 0);
      rx_buf_ready = ($urandom_range(0, 99) < 85);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arq_flow_ctrl_mlt.md
ARQ_FLOW_CTRL_MLT -- requirements
Module: arq_flow_ctrl_mlt

Interface
REQ-001 SHALL have parameter NUM_LT, default 8, number of logical transports tracked (2..16).
REQ-002 SHALL have parameter LTW, default 3, LT index width, equal to ceil(log2(NUM_LT)).
REQ-003 SHALL have parameter MAX_RETX, default 7, retransmissions allowed before an auto-flush (1..15).
REQ-004 SHALL have ports:
  clk_6M  in  1  sole clock
  rst  in  1  asynchronous, active-high reset
  conn_new_p  in  1  new connection; reinitialise all LT state
  tx_start_p  in  1  TX slot start for tx_lt
  tx_lt  in  LTW  LT being transmitted
  tx_is_data  in  1  scheduled packet is an ACL data type
  flush_req_p  in  1  host flush request for flush_lt
  flush_lt  in  LTW  LT to flush
  rx_done_p  in  1  RX payload-end strobe
  rx_lt  in  LTW  decoded LT_ADDR
  rx_hec_ok, rx_crc_ok, rx_mic_ok  in  1 each  decoder checks
  rx_is_data  in  1  received type carries an ACL payload
  rx_seqn, rx_arqn, rx_flow  in  1 each  decoded header bits
  rx_buf_ready  in  1  local RX buffer can take one payload
  tx_seqn, tx_arqn, tx_flow  out  1 each  header bits for the tx_lt packet
  tx_sel  out  2  0 new payload, 1 retransmit, 2 zero-length continue, 3 NULL
  rx_accept_p, rx_ignore_p, rx_reject_p  out  1 each  RX verdict strobes
  retx_drop_p  out  1  auto-flush fired
  lt_arqn_vec, lt_stop_vec  out  NUM_LT each  per-LT ARQN and remote STOP state

Function
REQ-005 Per-LT TX FSM SHALL have the states IDLE, WAIT_ACK and FLUSH, with a 4-bit retx_cnt.
REQ-006 On tx_start_p with tx_is_data=1 while lt_stop_vec[tx_lt]=1: tx_sel=3; no state, SEQN or counter change.
REQ-007 IDLE with data: tx_sel=0; toggle SEQN[tx_lt]; go to WAIT_ACK; clear retx_cnt.
REQ-008 WAIT_ACK with data and retx_cnt<MAX_RETX: tx_sel=1; SEQN unchanged; increment retx_cnt.
REQ-009 WAIT_ACK with data and retx_cnt==MAX_RETX: pulse retx_drop_p; tx_sel=2; go to FLUSH.
REQ-010 FLUSH with data: tx_sel=2; SEQN unchanged.
REQ-011 tx_start_p with tx_is_data=0: tx_sel=0; FSM and SEQN unchanged.
REQ-012 flush_req_p SHALL move the flush_lt FSM from WAIT_ACK to FLUSH, and SHALL be ignored in IDLE or FLUSH.
REQ-013 rx_done_p with rx_hec_ok=1 and rx_arqn=1 SHALL move the rx_lt FSM from WAIT_ACK or FLUSH to IDLE.
REQ-014 rx_done_p with rx_hec_ok=1 SHALL load lt_stop_vec[rx_lt] with ~rx_flow.
REQ-015 TX outputs (tx_seqn, tx_arqn, tx_flow, tx_sel) SHALL be registered, valid one cycle after tx_start_p, and held until the next tx_start_p.
REQ-016 tx_arqn SHALL equal lt_arqn_vec[tx_lt], and tx_flow SHALL equal rx_buf_ready, both sampled at tx_start_p.
REQ-017 RX verdicts SHALL be registered one-cycle strobes following rx_done_p, with exactly one strobe per rx_done_p.
REQ-018 hec fail: reject; no per-LT update.
REQ-019 Data type with rx_seqn==SEQN_old[rx_lt]: ignore; ARQN=1.
REQ-020 Data type with new SEQN and crc, mic and buffer all ok: accept; SEQN_old<=rx_seqn; ARQN=1.
REQ-021 Data type with new SEQN and crc fail, mic fail or rx_buf_ready=0: reject; ARQN=0; SEQN_old unchanged.
REQ-022 Non-data type: reject strobe; ARQN, SEQN_old and the FSM keep their values, except the ack and flow rules (REQ-013, REQ-014), which still apply.
REQ-023 Same cycle, same LT, tx_start_p and rx_done_p: the ACK SHALL be applied first, so that tx_start_p sees IDLE.
REQ-024 Same cycle, flush_req_p and an ACK for the same LT: the ACK SHALL win and the FSM SHALL go to IDLE.
REQ-025 conn_new_p SHALL override all other events and SHALL set, for every LT: SEQN=1, SEQN_old=0, ARQN=0, STOP=0, state IDLE, retx_cnt=0.
REQ-026 LT indices >= NUM_LT SHALL be ignored; no state changes and no strobes result.

Reset
REQ-027 While rst=1, all state SHALL take the conn_new_p values, and outputs SHALL be: tx_seqn=1, tx_arqn=0, tx_flow=0, tx_sel=3, all strobes 0, both vectors 0.
REQ-028 Reset asserted mid-slot SHALL abandon the slot with no residual strobe after release.

Structure
REQ-029 Package arq_pkg SHALL hold the TX-state and tx_sel encodings and the NUM_LT/MAX_RETX defaults.
REQ-030 The per-LT TX FSM plus retx_cnt SHALL be sub-module arq_lt_txfsm, with NUM_LT instances generated.

Verification
REQ-031 conn_new_p, then tx_start_p on LT 2 with data -> tx_sel=0, tx_seqn=0; ACK; tx_start_p -> tx_sel=0, tx_seqn=1.
REQ-032 No ACK across 8 tx_start_p on LT 1 with MAX_RETX=7 -> seven tx_sel=1, then retx_drop_p and tx_sel=2; ACK -> next tx_sel=0.
REQ-033 rx_done_p on LT 3 with seqn 1, all checks good -> accept, lt_arqn_vec[3]=1; repeat the same packet -> ignore; seqn 0 with crc fail -> reject, ARQN 0.
REQ-034 rx_buf_ready=0 on a new data packet -> reject, ARQN=0, next tx_flow=0.
REQ-035 rx_flow=0 on LT 4 -> data tx_start_p gives tx_sel=3; rx_flow=1 -> sending resumes.
REQ-036 Same-cycle ACK plus tx_start_p, and ACK plus flush_req_p, on LT 0 -> tx_sel=0 and state IDLE respectively.
